uart_tx_fifo: RTL and testbench

- Downstream output stage: serializes 8-bit results from the filter/FFT datapath onto the board UART TX pin.
- Format is 8N1: 1 start bit, 8 data bits LSB first, 1 stop bit.
- A small input FIFO absorbs bursts, so the producer can push several bytes back-to-back with a valid/ready handshake.
- Sits between the processing pipeline and the top-level `tx` pin.

---
 rtl/uart_tx_fifo.sv | 192 +++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : uart_tx_fifo
// Description : 8N1 UART transmitter fed by a small byte FIFO. Bytes are
//               accepted with a valid/ready handshake and sent LSB first,
//               back-to-back with no idle gap while the FIFO holds data.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 4,
    parameter int CNT_W        = 3
) (
    input  logic             clk,
    input  logic             rst,          // asynchronous, active-low
    input  logic [7:0]       din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             tx,
    output logic             busy,
    output logic [CNT_W-1:0] fifo_count
);

    localparam int c_PTR_W  = $clog2(FIFO_DEPTH);
    localparam int c_BAUD_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [c_BAUD_W-1:0] c_BAUD_LAST = c_BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [c_BAUD_W-1:0] c_BAUD_ONE  = c_BAUD_W'(1);
    localparam logic [c_PTR_W-1:0]  c_PTR_ONE   = c_PTR_W'(1);
    localparam logic [CNT_W-1:0]    c_CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]    c_DEPTH     = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    // Registered state
    state_t               r_state;
    logic [7:0]           r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]     r_count;
    logic [7:0]           r_shift;
    logic [2:0]           r_bit_idx;
    logic [c_BAUD_W-1:0]  r_baud;
    logic                 r_tx;

    // Combinational control
    state_t               w_state_next;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_fifo_nempty;
    logic                 w_baud_done;
    logic                 w_shift_en;
    logic                 w_tx_next;

    assign w_fifo_nempty = (r_count != '0);
    assign w_baud_done   = (r_baud == c_BAUD_LAST);
    // Ready comes only from the registered count, so a pop in the same
    // cycle never opens a slot while the FIFO is full.
    assign din_ready     = (r_count < c_DEPTH);
    assign w_push        = din_valid & din_ready;

    assign tx            = r_tx;
    assign fifo_count    = r_count;
    assign busy          = (r_state != S_IDLE) | w_fifo_nempty;

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state, pop request and the value the tx flop takes next cycle
    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        w_shift_en   = 1'b0;
        w_tx_next    = 1'b1;
        case (r_state)
            S_IDLE: begin
                if (w_fifo_nempty) begin
                    w_pop        = 1'b1;
                    w_tx_next    = 1'b0;
                    w_state_next = S_START;
                end
            end
            S_START: begin
                w_tx_next = 1'b0;
                if (w_baud_done) begin
                    w_tx_next    = r_shift[0];
                    w_state_next = S_DATA;
                end
            end
            S_DATA: begin
                w_tx_next = r_shift[0];
                if (w_baud_done) begin
                    w_shift_en = 1'b1;
                    if (r_bit_idx == 3'd7) begin
                        w_tx_next    = 1'b1;
                        w_state_next = S_STOP;
                    end else begin
                        w_tx_next = r_shift[1];
                    end
                end
            end
            S_STOP: begin
                w_tx_next = 1'b1;
                if (w_baud_done) begin
                    if (w_fifo_nempty) begin
                        // Chain straight into the next start bit
                        w_pop        = 1'b1;
                        w_tx_next    = 1'b0;
                        w_state_next = S_START;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Baud counter, shift register, bit index and the tx output flop
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_baud    <= '0;
            r_shift   <= '0;
            r_bit_idx <= '0;
            r_tx      <= 1'b1;
        end else begin
            r_tx <= w_tx_next;

            if (w_pop || (r_state == S_IDLE) || w_baud_done) begin
                r_baud <= '0;
            end else begin
                r_baud <= r_baud + c_BAUD_ONE;
            end

            if (w_pop) begin
                r_shift <= r_mem[r_rd_ptr];
            end else if (w_shift_en) begin
                r_shift <= {1'b0, r_shift[7:1]};
            end

            if (r_state != S_DATA) begin
                r_bit_idx <= '0;
            end else if (w_shift_en) begin
                r_bit_idx <= r_bit_idx + 3'd1;
            end
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally (power-of-2 depth)
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // FIFO storage; contents need no reset since the count gates reads
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_uart_tx_fifo
// Description : Directed self-checking bench for uart_tx_fifo with
//               CLKS_PER_BIT=4 and FIFO_DEPTH=4.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int CW    = 3;

    logic          clk;
    logic          rst;
    logic [7:0]    din;
    logic          din_valid;
    logic          din_ready;
    logic          tx;
    logic          busy;
    logic [CW-1:0] fifo_count;

    int   n_cmp = 0;
    int   n_err = 0;
    int   peak;
    int   w;
    int   bad;
    logic acc;
    logic exp_q[$];

    uart_tx_fifo #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH),
        .CNT_W        (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .tx         (tx),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts and reports
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Append the per-cycle tx levels of one 8N1 frame to the expected stream
    task automatic add_frame(input logic [7:0] b);
        logic [9:0] bits;
        bits = {1'b1, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            for (int j = 0; j < CPB; j++) begin
                exp_q.push_back(bits[i]);
            end
        end
    endtask

    // Called just after a posedge; byte is captured on the next posedge
    task automatic push_byte(input logic [7:0] b);
        din       = b;
        din_valid = 1'b1;
        @(posedge clk);
        #1;
        din_valid = 1'b0;
    endtask

    // Started together with the first push: skips the pre-push cycle and
    // the push cycle, then checks tx on every following negedge
    task automatic watch_stream(input string tag);
        int i;
        i    = 0;
        peak = 0;
        repeat (2) @(negedge clk);
        while (exp_q.size() > 0) begin
            @(negedge clk);
            if (int'(fifo_count) > peak) peak = int'(fifo_count);
            check($sformatf("%s_tx%0d", tag, i), tx, exp_q.pop_front());
            i++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst       = 1'b0;
        din       = 8'h00;
        din_valid = 1'b0;

        // Reset values
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("rst_tx",    tx,         1);
        check("rst_busy",  busy,       0);
        check("rst_count", fifo_count, 0);
        check("rst_ready", din_ready,  1);
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("idle_tx%0d", i), tx, 1);
        end
        check("idle_busy", busy, 0);

        // Single byte 0xA5
        @(posedge clk); #1;
        add_frame(8'hA5);
        fork
            begin
                push_byte(8'hA5);
                check("a5_count", fifo_count, 1);
            end
            watch_stream("a5");
        join
        check("a5_busy_stop", busy, 1);
        @(negedge clk);
        check("a5_busy_end", busy, 0);
        check("a5_tx_end", tx, 1);
        check("a5_count_end", fifo_count, 0);

        // Back-to-back 0x01, 0x02, 0x03
        @(posedge clk); #1;
        add_frame(8'h01);
        add_frame(8'h02);
        add_frame(8'h03);
        fork
            begin
                push_byte(8'h01);
                push_byte(8'h02);
                push_byte(8'h03);
            end
            watch_stream("b2b");
        join
        check("b2b_peak", peak, 2);
        @(negedge clk);
        check("b2b_busy_end", busy, 0);

        // Full FIFO with a held fifth push
        @(posedge clk); #1;
        add_frame(8'h55);
        add_frame(8'h11);
        add_frame(8'h22);
        add_frame(8'h33);
        add_frame(8'h44);
        add_frame(8'h99);
        fork
            begin
                push_byte(8'h55);
                push_byte(8'h11);
                push_byte(8'h22);
                push_byte(8'h33);
                push_byte(8'h44);
                check("full_count", fifo_count, 4);
                check("full_ready", din_ready, 0);
                din       = 8'h99;
                din_valid = 1'b1;
                w         = 0;
                acc       = 1'b0;
                while (!acc && w < 100) begin
                    @(negedge clk);
                    w++;
                    acc = din_ready;
                    @(posedge clk);
                    #1;
                end
                din_valid = 1'b0;
                check("full_wait", w, 38);
                check("full_count_after", fifo_count, 4);
            end
            watch_stream("full");
        join
        @(negedge clk);
        check("full_busy_end", busy, 0);

        // Push on the same edge as the pop at the end of STOP
        @(posedge clk); #1;
        add_frame(8'h3C);
        add_frame(8'hC3);
        add_frame(8'h7E);
        fork
            begin
                push_byte(8'h3C);
                push_byte(8'hC3);
                repeat (39) @(posedge clk);
                #1;
                check("pp_before", fifo_count, 1);
                push_byte(8'h7E);
                check("pp_after", fifo_count, 1);
            end
            watch_stream("pp");
        join
        @(negedge clk);
        check("pp_busy_end", busy, 0);

        // Reset during data bit 3 of 0xFF with two bytes queued
        @(posedge clk); #1;
        push_byte(8'hFF);
        push_byte(8'h12);
        push_byte(8'h34);
        repeat (17) @(posedge clk);
        #3;
        check("mid_busy", busy, 1);
        check("mid_count", fifo_count, 2);
        rst = 1'b0;
        #1;
        check("mid_rst_tx", tx, 1);
        check("mid_rst_count", fifo_count, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_ready", din_ready, 1);
        @(negedge clk);
        rst = 1'b1;
        bad = 0;
        repeat (60) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        check("post_rst_quiet", bad, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
